// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             pout,
    output logic             gout
);
    localparam int NSTG = WIDTH / GROUP;

    if (GROUP > WIDTH || WIDTH % GROUP != 0) begin : g_bad_params
        $error("cla_pipe_adder: GROUP must divide WIDTH");
    end

    // returns {group P, group G, c[GROUP:0]}; c[i] = G[i-1:0] | P[i-1:0] & ci
    function automatic logic [GROUP+2:0] la(input logic [GROUP-1:0] p, g, input logic ci);
        logic [GROUP:0] c;
        logic tp, tg;
        tp = 1'b1;
        tg = 1'b0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            tg = g[i] | p[i] & tg;
            tp = tp & p[i];
            c[i+1] = tg | tp & ci;
        end
        return {tp, tg, c};
    endfunction

    logic adv;
    assign adv = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] xa, xb, xs, ns, rs;
        logic xv, xc, xp, xg, gp, gg, rv, rc, rp, rg;
        logic [GROUP-1:0] p, g;
        logic [GROUP:0] c;
        if (k == 0) begin : g_in
            assign xv = in_valid;
            assign xa = a;
            assign xb = sub ? ~b : b;
            assign xc = sub | cin;
            assign xp = 1'b1;
            assign xg = 1'b0;
            assign xs = '0;
        end else begin : g_in
            assign xv = g_stg[k-1].rv;
            assign xa = g_stg[k-1].g_op.ra;
            assign xb = g_stg[k-1].g_op.rb;
            assign xc = g_stg[k-1].rc;
            assign xp = g_stg[k-1].rp;
            assign xg = g_stg[k-1].rg;
            assign xs = g_stg[k-1].rs;
        end
        assign p = xa[GROUP-1:0] ^ xb[GROUP-1:0];
        assign g = xa[GROUP-1:0] & xb[GROUP-1:0];
        assign {gp, gg, c} = la(p, g, xc);
        // sum bits enter at the top and shift down, so the word is aligned after the last stage
        assign ns = WIDTH'({p ^ c[GROUP-1:0], xs} >> GROUP);
        always_ff @(posedge clk) begin
            if (rst) begin
                rv <= 1'b0;
                rs <= '0;
                rc <= 1'b0;
                rp <= 1'b0;
                rg <= 1'b0;
            end else if (adv) begin
                rv <= xv;
                rs <= ns;
                rc <= c[GROUP];
                rp <= xp & gp;
                rg <= gg | gp & xg;
            end
        end
        if (k < NSTG - 1) begin : g_op
            logic [WIDTH-1:0] ra, rb;
            always_ff @(posedge clk) begin
                if (adv) begin
                    ra <= xa >> GROUP;
                    rb <= xb >> GROUP;
                end
            end
        end
        if (k == NSTG - 1) begin : g_last
            logic ro;
            always_ff @(posedge clk) begin
                if (rst)
                    ro <= 1'b0;
                else if (adv)
                    ro <= c[GROUP] ^ c[GROUP-1];
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].rv;
    assign sum       = g_stg[NSTG-1].rs;
    assign cout      = g_stg[NSTG-1].rc;
    assign pout      = g_stg[NSTG-1].rp;
    assign gout      = g_stg[NSTG-1].rg;
    assign ovf       = g_stg[NSTG-1].g_last.ro;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: random and directed stimulus against an arithmetic reference model
module tb_cla_pipe_adder;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf, pout, gout;
    logic [15:0] sum;
    int          checks = 0, failures = 0;
    logic [19:0] q[$];

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .pout(pout), .gout(gout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {sum, cout, ovf, pout, gout} from plain 17-bit arithmetic
    function automatic logic [19:0] ref_model(input logic [15:0] x, y, input logic ci, su);
        logic [15:0] yp;
        logic [16:0] full, nc;
        logic        v;
        yp   = su ? ~y : y;
        full = {1'b0, x} + {1'b0, yp} + 17'(su | ci);
        nc   = {1'b0, x} + {1'b0, yp};
        v    = (x[15] == yp[15]) && (full[15] != x[15]);
        return {full[15:0], full[16], v, (x ^ yp) == 16'hFFFF, nc[16]};
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (rst) q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 32'(q.size()), 1);
                else chk("beat", {sum, cout, ovf, pout, gout}, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(ref_model(a, b, cin, sub));
        end
    end

    task automatic directed(input string tag, input logic [15:0] da, db, input logic dc, ds,
                            input logic [19:0] exp);
        int n;
        @(negedge clk); #1;
        in_valid = 1'b1; a = da; b = db; cin = dc; sub = ds; out_ready = 1'b1;
        @(negedge clk); #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
        n = 1;
        #2;
        while (!out_valid && n < 20) begin
            @(negedge clk); #3;
            n++;
        end
        chk({tag, "_lat"}, n, 4);
        chk(tag, {sum, cout, ovf, pout, gout}, exp);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        @(negedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        #2;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk); #3;
            n++;
        end
        chk(tag, 32'(q.size()), 0);
    endtask

    initial begin
        int acc, cyc, n;
        logic [19:0] snap;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_outs", {sum, cout, ovf, pout, gout}, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        #2;
        chk("rst_ready", in_ready, 1);

        directed("add",   16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 4'b0000});
        directed("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 4'b1001});
        directed("ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b0100});
        directed("prop",  16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 4'b1010});
        directed("sub",   16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 4'b0000});
        directed("subov", 16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 4'b1101});

        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #1;
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
        end
        drain("rand_drain");

        acc = 0;
        cyc = 0;
        snap = '0;
        while (acc < 8 && cyc < 40) begin
            @(negedge clk); #1;
            out_ready = !(cyc >= 5 && cyc < 8);
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            #2;
            if (!out_ready) begin
                chk("hold_ready", in_ready, 0);
                if (cyc == 5) snap = {sum, cout, ovf, pout, gout};
                else chk("hold_stable", {sum, cout, ovf, pout, gout}, snap);
            end
            if (in_ready) acc++;
            cyc++;
        end
        chk("bp_accepted", acc, 8);
        @(negedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        #2;
        while (q.size() != 0 && n < 30) begin
            chk("no_gap", out_valid, 1);
            @(negedge clk); #3;
            n++;
        end
        chk("bp_drain", 32'(q.size()), 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
        end
        @(negedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rst_quiet", out_valid, 0);
            @(negedge clk); #1;
        end
        directed("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 4'b0000});
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
